// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the FIFO-fed UART transmitter:
//   - parity mode codes carried on the 3-bit pbit input
//   - serialiser state encoding
//   - parity_bit(): parity of the low dbit bits of a data word
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  // Widest word parity_bit() accepts; dbit is 4 bits so 15 data bits is the ceiling.
  localparam int unsigned PAR_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK,
    ST_MAB
  } tx_state_t;

  // Bits at or above position dbit are ignored. Codes 5..7 and PAR_NONE return 0.
  function automatic logic parity_bit(input logic [PAR_DATA_W-1:0] data,
                                      input logic [3:0]            dbit,
                                      input logic [2:0]            pbit);
    logic x;
    x = 1'b0;
    for (int unsigned i = 0; i < PAR_DATA_W; i++) begin
      if (i < 32'(dbit)) x = x ^ data[i];
    end
    case (pbit)
      PAR_EVEN:  return x;
      PAR_ODD:   return ~x;
      PAR_MARK:  return 1'b1;
      PAR_SPACE: return 1'b0;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with first-word-fall-through read data.
//   clk, reset   : clock, asynchronous active-high reset (empties the FIFO)
//   i_wr, i_din  : push request and data; ignored when full unless a pop
//                  happens in the same cycle
//   i_rd         : pop request; ignored when empty
//   o_dout       : head word (valid while !o_empty)
//   o_full/o_empty/o_count : occupancy status, count is 0..2**AW
//   o_overflow   : high during a cycle where a push is dropped
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count,
  output logic             o_overflow
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_empty;
  logic w_do_rd;
  logic w_do_wr;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_do_rd = i_rd && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign w_do_wr = i_wr && (!w_full || w_do_rd);

  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout     = r_mem[r_rptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_count    = r_count;
  assign o_overflow = i_wr && w_full && !w_do_rd;

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter fed from an internal FIFO, with CTS flow control, parity
// modes (none/even/odd/mark/space) and break generation.
//   clk, reset       : clock, asynchronous active-high reset
//   dbit, pbit       : data bits per frame (clamped to 5..DBIT), parity mode
//   os_tick, sb_tick : s_ticks per bit and per stop period (0 means 1)
//   s_tick           : oversample strobe, one clk wide
//   wr, din          : push a word into the FIFO
//   cts_n            : clear-to-send (active low), checked only between frames
//   brk              : break request (level)
//   full, empty, count, overflow : FIFO status
//   tx_busy          : serialiser not idle
//   tx_done_tick     : one-clk pulse at the end of each frame's stop period
//   tx               : registered serial output
// Frame settings are captured when a word is popped, so the live inputs can be
// changed while a frame is on the line.
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 9,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         dbit,
  input  logic [2:0]         pbit,
  input  logic [7:0]         os_tick,
  input  logic [7:0]         sb_tick,
  input  logic               s_tick,
  input  logic               wr,
  input  logic [DBIT-1:0]    din,
  input  logic               cts_n,
  input  logic               brk,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   count,
  output logic               overflow,
  output logic               tx_busy,
  output logic               tx_done_tick,
  output logic               tx
);

  localparam logic [3:0] DBIT_MAX = 4'(DBIT);
  localparam logic [3:0] DBIT_MIN = 4'd5;

  tx_state_t r_state, w_state_nxt;
  logic [7:0]      r_s, w_s_nxt;
  logic [3:0]      r_n, w_n_nxt;
  logic [DBIT-1:0] r_data, w_data_nxt;
  logic [3:0]      r_dbit, w_dbit_nxt;
  logic            r_par_en, w_par_en_nxt;
  logic            r_par, w_par_nxt;
  logic [7:0]      r_os, w_os_nxt;
  logic [7:0]      r_sb, w_sb_nxt;
  logic            r_tx, w_tx_nxt;
  logic            r_done, w_done_nxt;

  logic            w_pop;
  logic [DBIT-1:0] w_head;
  logic            w_empty;
  logic [3:0]      w_dbit_clamped;
  logic [7:0]      w_os_fix;
  logic [7:0]      w_sb_fix;
  logic            w_os_last;
  logic            w_sb_last;
  logic            w_cur_bit;

  uart_sync_fifo #(
    .WIDTH (DBIT),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_wr       (wr),
    .i_din      (din),
    .i_rd       (w_pop),
    .o_dout     (w_head),
    .o_full     (full),
    .o_empty    (w_empty),
    .o_count    (count),
    .o_overflow (overflow)
  );

  assign w_dbit_clamped = (dbit < DBIT_MIN) ? DBIT_MIN :
                          (dbit > DBIT_MAX) ? DBIT_MAX : dbit;
  assign w_os_fix  = (os_tick == '0) ? 8'd1 : os_tick;
  assign w_sb_fix  = (sb_tick == '0) ? 8'd1 : sb_tick;
  assign w_os_last = (r_s == r_os - 8'd1);
  assign w_sb_last = (r_s == r_sb - 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_s      <= '0;
      r_n      <= '0;
      r_data   <= '0;
      r_dbit   <= DBIT_MIN;
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
      r_os     <= 8'd1;
      r_sb     <= 8'd1;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_s      <= w_s_nxt;
      r_n      <= w_n_nxt;
      r_data   <= w_data_nxt;
      r_dbit   <= w_dbit_nxt;
      r_par_en <= w_par_en_nxt;
      r_par    <= w_par_nxt;
      r_os     <= w_os_nxt;
      r_sb     <= w_sb_nxt;
      r_tx     <= w_tx_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_s_nxt      = r_s;
    w_n_nxt      = r_n;
    w_data_nxt   = r_data;
    w_dbit_nxt   = r_dbit;
    w_par_en_nxt = r_par_en;
    w_par_nxt    = r_par;
    w_os_nxt     = r_os;
    w_sb_nxt     = r_sb;
    w_done_nxt   = 1'b0;
    w_pop        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (brk) begin
          w_state_nxt = ST_BREAK;
          w_s_nxt     = '0;
          w_sb_nxt    = w_sb_fix;
        end else if (!w_empty && !cts_n) begin
          w_pop        = 1'b1;
          w_data_nxt   = w_head;
          w_dbit_nxt   = w_dbit_clamped;
          w_par_en_nxt = (pbit >= PAR_EVEN) && (pbit <= PAR_SPACE);
          w_par_nxt    = parity_bit(PAR_DATA_W'(w_head), w_dbit_clamped, pbit);
          w_os_nxt     = w_os_fix;
          w_sb_nxt     = w_sb_fix;
          w_state_nxt  = ST_START;
          w_s_nxt      = '0;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (w_os_last) begin
            w_state_nxt = ST_DATA;
            w_s_nxt     = '0;
            w_n_nxt     = '0;
          end else begin
            w_s_nxt = r_s + 8'd1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (w_os_last) begin
            w_s_nxt = '0;
            if (r_n == r_dbit - 4'd1) begin
              w_state_nxt = r_par_en ? ST_PARITY : ST_STOP;
            end else begin
              w_n_nxt = r_n + 4'd1;
            end
          end else begin
            w_s_nxt = r_s + 8'd1;
          end
        end
      end

      ST_PARITY: begin
        if (s_tick) begin
          if (w_os_last) begin
            w_state_nxt = ST_STOP;
            w_s_nxt     = '0;
          end else begin
            w_s_nxt = r_s + 8'd1;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (w_sb_last) begin
            w_state_nxt = ST_IDLE;
            w_s_nxt     = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_s_nxt = r_s + 8'd1;
          end
        end
      end

      ST_BREAK: begin
        if (!brk) begin
          w_state_nxt = ST_MAB;
          w_s_nxt     = '0;
        end
      end

      ST_MAB: begin
        if (s_tick) begin
          if (w_sb_last) begin
            w_state_nxt = ST_IDLE;
            w_s_nxt     = '0;
          end else begin
            w_s_nxt = r_s + 8'd1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_s_nxt     = '0;
      end
    endcase
  end

  // The line level is derived from the next state so the registered tx
  // follows a state change by exactly one clk.
  always_comb begin
    w_cur_bit = 1'b0;
    for (int unsigned i = 0; i < DBIT; i++) begin
      if (i == 32'(w_n_nxt)) w_cur_bit = w_data_nxt[i];
    end

    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_BREAK:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_cur_bit;
      ST_PARITY: w_tx_nxt = w_par_nxt;
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  assign empty        = w_empty;
  assign tx_busy      = (r_state != ST_IDLE);
  assign tx_done_tick = r_done;
  assign tx           = r_tx;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Second-generation UART transmitter with a built-in transmit FIFO, CTS flow control, extended parity modes and break generation. The host pushes words into the FIFO. The serialiser drains it one frame at a time, paced by the shared baud-rate s_tick strobe. Frame configuration is latched per frame, so software can change settings without corrupting a frame in flight.

Parameters:
DBIT, 9, maximum data bits per frame and FIFO word width (min 5)
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
dbit  in  4  data bits per frame, legal 5..DBIT
pbit  in  3  parity: 0=none, 1=even, 2=odd, 3=mark(1), 4=space(0); 5-7 treated as none
os_tick  in  8  s_ticks per bit (e.g. 16)
sb_tick  in  8  s_ticks for stop period (os_tick, 1.5*os_tick, 2*os_tick)
s_tick  in  1  oversample strobe, one clk wide
wr  in  1  push din into FIFO
din  in  DBIT  data word, LSB transmitted first
cts_n  in  1  clear-to-send, active low, already synchronised
brk  in  1  break request, level
full  out  1  FIFO full
empty  out  1  FIFO empty
count  out  FIFO_AW+1  FIFO occupancy, 0..2**FIFO_AW
overflow  out  1  one-clk pulse when wr is asserted while full and no pop occurs
tx_busy  out  1  high in any state except IDLE
tx_done_tick  out  1  one-clk pulse at end of each frame's stop period
tx  out  1  serial line, registered

Behaviour:
- Reset (async): FIFO emptied (count=0, empty=1, full=0); state IDLE; tx=1; tx_busy=0; tx_done_tick=0; overflow=0.
- FIFO: synchronous write on wr&&!full. Pop and write in the same cycle when full: both occur, count unchanged, no overflow. Write into an empty FIFO is not poppable until the next cycle.
- States: IDLE, START, DATA, PARITY, STOP, BREAK, MAB (mark-after-break).
- IDLE: tx_next=1.
  - If brk=1, go to BREAK. Break has priority over queued data.
  - Else if !empty && !cts_n: pop the head word and latch configuration into shadow registers, then go to START.
  - Latched configuration: dbit, pbit, os_tick, sb_tick, and parity computed over the low dbit bits of the popped word.
- START: tx_next=0 for os_tick s_ticks, then go to DATA with n=0.
- DATA: tx_next=data[n] for os_tick s_ticks per bit. After bit dbit-1, go to PARITY if the latched pbit is 1..4, else to STOP.
- PARITY: tx_next=parity bit for os_tick s_ticks, then go to STOP.
- STOP: tx_next=1 for sb_tick s_ticks. On the final tick: pulse tx_done_tick and go to IDLE. Back-to-back frames therefore have no extra idle bit.
- BREAK: tx_next=0 while brk=1. On brk falling, go to MAB. MAB holds tx=1 for sb_tick s_ticks, then goes to IDLE. No tx_done_tick is issued for a break.
- brk asserted mid-frame: the frame completes normally; BREAK is entered from the next IDLE.
- cts_n: sampled only in IDLE. Deassertion mid-frame never aborts or stretches the frame.
- Counters:
  - s counter is 8-bit and advances only on s_tick; it resets to 0 at each state or bit transition.
  - os_tick=0 or sb_tick=0 is treated as 1.
  - A dbit value outside 5..DBIT is clamped into that range at latch time.
- Timing: tx is registered, so the line changes one clk after a state transition. From pop (IDLE cycle) to tx=0 is 1 clk.
- Live config inputs changing mid-frame have no effect until the next pop.

Decomposition:
- Shared package uart_pkg holds:
  - parity mode constants PAR_NONE/EVEN/ODD/MARK/SPACE;
  - the state encoding enum for the seven states;
  - a function parity_bit(data, dbit, pbit) that masks data above dbit.
- One sub-module: uart_sync_fifo (parameters WIDTH, AW), providing full/empty/count and simultaneous read/write.
- The serialiser FSM lives in the top level.

Test Plan:
- dbit=8, pbit=0, os_tick=16, sb_tick=16; push 0x55 -> tx shows start 0, bits 1,0,1,0,1,0,1,0, stop 1; frame lasts 160 s_ticks; one tx_done_tick.
- dbit=7, pbit=1 (even), push 0x03 -> 7 data bits 1,1,0,0,0,0,0, parity 0. Repeat with pbit=2 (parity 1), pbit=3 (1), pbit=4 (0); bit 7 of din is ignored.
- cts_n=1, push 3 words -> tx stays 1, count=3. Release cts_n -> 3 back-to-back frames, each stop of sb_tick s_ticks, then empty=1. Raising cts_n during frame 2 lets frame 2 finish, and frame 3 waits.
- FIFO_AW=2: push 5 words with cts_n=1 -> full=1 after 4 pushes, overflow pulses on the 5th, count=4. A pop and write in the same full cycle gives count=4 and no overflow.
- brk=1 during a frame -> the frame completes, then tx=0 for as long as brk is held. On release, tx=1 for sb_tick s_ticks, then the next queued frame starts; no tx_done_tick is issued for the break.
- Reset asserted mid-DATA -> tx=1 immediately (async), count=0, tx_busy=0; after release and a new push, the frame is correct.
